// File: rtl/ss_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment blocks: scan states, blank code and the hex font.
package ss_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_SHOW_L   = 2'd0,
      ST_BLANK_LR = 2'd1,
      ST_SHOW_R   = 2'd2,
      ST_BLANK_RL = 2'd3
   } scan_state_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {G,F,E,D,C,B,A}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      unique case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/ss_hex_decode.sv
// Combinational nibble to active-low 7-segment code.
module ss_hex_decode
   import ss_scan_ctrl_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/ss_scan_ctrl.sv
// Dual-digit 7-segment scan controller: time-multiplexes one byte onto shared
// active-low segment lines with blank gaps, loading new values only at frame boundaries.
//
//  state       | meaning
//  ST_SHOW_L   | left digit lit (high nibble), ss_right = 0
//  ST_BLANK_LR | all segments off, going left -> right
//  ST_SHOW_R   | right digit lit (low nibble), ss_right = 1
//  ST_BLANK_RL | all segments off, going right -> left; leaving it is the frame boundary
module ss_scan_ctrl
   import ss_scan_ctrl_pkg::*;
#(
   parameter int DIGIT_CYCLES = 12000,
   parameter int BLANK_CYCLES = 120
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       ld_valid_i,
   input  logic [7:0] ld_data_i,
   output logic       ld_ready_o,
   input  logic       en_i,
   input  logic       lzb_i,
   output logic       ss_a_n_o,
   output logic       ss_b_n_o,
   output logic       ss_c_n_o,
   output logic       ss_d_n_o,
   output logic       ss_e_n_o,
   output logic       ss_f_n_o,
   output logic       ss_g_n_o,
   output logic       ss_right_o,
   output logic       frame_tick_o
);

   localparam int MAX_LEN = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   scan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       disp_q, disp_d;
   logic [7:0]       shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic [6:0]       seg_q, seg_d;
   logic             ss_right_q, ss_right_d;
   logic             frame_tick_q, frame_tick_d;

   logic             state_last;
   logic             boundary;
   logic             xfer;
   logic [3:0]       nib_sel;
   logic [6:0]       nib_seg;

   assign state_last = (state_q == ST_SHOW_L || state_q == ST_SHOW_R) ?
                       (cnt_q == SHOW_LAST) : (cnt_q == BLANK_LAST);
   assign boundary   = (state_q == ST_BLANK_RL) && state_last;
   assign xfer       = ld_valid_i && !pend_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      if (state_last) begin
         cnt_d = '0;
         unique case (state_q)
            ST_SHOW_L:   state_d = ST_BLANK_LR;
            ST_BLANK_LR: state_d = ST_SHOW_R;
            ST_SHOW_R:   state_d = ST_BLANK_RL;
            default:     state_d = ST_SHOW_L;
         endcase
      end
   end

   // A load arriving on the boundary edge with nothing pending goes straight to
   // the display so it is not held back a whole frame.
   always_comb begin
      disp_d   = disp_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      if (boundary) begin
         if (pend_q) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
         end else if (xfer) begin
            disp_d = ld_data_i;
         end
      end else if (xfer) begin
         shadow_d = ld_data_i;
         pend_d   = 1'b1;
      end
   end

   assign nib_sel = (state_d == ST_SHOW_R) ? disp_d[3:0] : disp_d[7:4];

   ss_hex_decode u_hex_decode (
      .nib_i (nib_sel),
      .seg_o (nib_seg)
   );

   // Outputs follow the next state so segments and digit select move on the state edge.
   always_comb begin
      seg_d        = SEG_OFF;
      ss_right_d   = ss_right_q;
      frame_tick_d = boundary;
      unique case (state_d)
         ST_SHOW_L: begin
            ss_right_d = 1'b0;
            if (en_i && !(lzb_i && disp_d[7:4] == 4'h0)) seg_d = nib_seg;
         end
         ST_SHOW_R: begin
            ss_right_d = 1'b1;
            if (en_i) seg_d = nib_seg;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_BLANK_RL;
         cnt_q        <= '0;
         disp_q       <= 8'h00;
         shadow_q     <= 8'h00;
         pend_q       <= 1'b0;
         seg_q        <= SEG_OFF;
         ss_right_q   <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         disp_q       <= disp_d;
         shadow_q     <= shadow_d;
         pend_q       <= pend_d;
         seg_q        <= seg_d;
         ss_right_q   <= ss_right_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign ld_ready_o   = ~pend_q;
   assign ss_a_n_o     = seg_q[0];
   assign ss_b_n_o     = seg_q[1];
   assign ss_c_n_o     = seg_q[2];
   assign ss_d_n_o     = seg_q[3];
   assign ss_e_n_o     = seg_q[4];
   assign ss_f_n_o     = seg_q[5];
   assign ss_g_n_o     = seg_q[6];
   assign ss_right_o   = ss_right_q;
   assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Bench for ss_scan_ctrl: directed scenarios plus random traffic against a frame-position model.
module tb_ss_scan_ctrl;

   localparam int DC    = 8;
   localparam int BC    = 2;
   localparam int FRAME = 2 * (DC + BC);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data = 8'h00;
   logic       ld_ready;
   logic       en = 1'b1;
   logic       lzb = 1'b0;
   logic       sa, sb, sc, sd, se, sf, sg;
   logic       ss_right;
   logic       frame_tick;
   logic [6:0] seg_obs;

   assign seg_obs = {sg, sf, se, sd, sc, sb, sa};

   always #5 clk = ~clk;

   ss_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .ld_valid_i   (ld_valid),
      .ld_data_i    (ld_data),
      .ld_ready_o   (ld_ready),
      .en_i         (en),
      .lzb_i        (lzb),
      .ss_a_n_o     (sa),
      .ss_b_n_o     (sb),
      .ss_c_n_o     (sc),
      .ss_d_n_o     (sd),
      .ss_e_n_o     (se),
      .ss_f_n_o     (sf),
      .ss_g_n_o     (sg),
      .ss_right_o   (ss_right),
      .frame_tick_o (frame_tick)
   );

   logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int n_tests = 0;
   int n_fail  = 0;

   // Model: position within the frame (0 = first cycle of the left digit),
   // the shown byte and a one-deep queue of accepted-but-not-shown bytes.
   int         m_pos;
   logic [7:0] m_disp;
   logic [7:0] m_q [$];
   logic       m_sr;
   logic       m_tick;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] m_seg();
      if (!en) return 7'h7F;
      if (m_pos < DC) begin
         if (lzb && m_disp[7:4] == 4'h0) return 7'h7F;
         return font[m_disp[7:4]];
      end
      if (m_pos >= DC + BC && m_pos < 2 * DC + BC) return font[m_disp[3:0]];
      return 7'h7F;
   endfunction

   task automatic model_edge();
      bit xfer;
      xfer  = ld_valid && (m_q.size() == 0);
      m_pos = (m_pos + 1) % FRAME;
      if (m_pos == 0) begin
         if (m_q.size() != 0) m_disp = m_q.pop_front();
         else if (xfer)       m_disp = ld_data;
      end else if (xfer) begin
         m_q.push_back(ld_data);
      end
      m_tick = (m_pos == 0);
      if (m_pos < DC) m_sr = 1'b0;
      else if (m_pos >= DC + BC && m_pos < 2 * DC + BC) m_sr = 1'b1;
   endtask

   task automatic step();
      logic [6:0] seg_prev;
      logic       sr_prev;
      logic [6:0] exp_seg;
      seg_prev = seg_obs;
      sr_prev  = ss_right;
      @(posedge clk);
      model_edge();
      exp_seg = m_seg();
      #1;
      chk("seg", {1'b0, seg_obs}, {1'b0, exp_seg});
      chk("ss_right", {7'b0, ss_right}, {7'b0, m_sr});
      chk("frame_tick", {7'b0, frame_tick}, {7'b0, m_tick});
      chk("ld_ready", {7'b0, ld_ready}, {7'b0, (m_q.size() == 0)});
      if (ss_right !== sr_prev) chk("ghost", {1'b0, seg_prev}, 8'h7F);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_pos(input int p);
      for (int i = 0; i < FRAME && m_pos != p; i++) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_seg", {1'b0, seg_obs}, 8'h7F);
      chk("rst_ss_right", {7'b0, ss_right}, 8'h00);
      chk("rst_ready", {7'b0, ld_ready}, 8'h01);
      chk("rst_tick", {7'b0, frame_tick}, 8'h00);
      @(posedge clk);
      #1;
      chk("rst_hold_seg", {1'b0, seg_obs}, 8'h7F);
      chk("rst_hold_ready", {7'b0, ld_ready}, 8'h01);
      @(negedge clk);
      rst_n  = 1'b1;
      m_pos  = FRAME - BC;
      m_disp = 8'h00;
      m_q.delete();
      m_sr   = 1'b0;
      m_tick = 1'b0;
   endtask

   task automatic load(input logic [7:0] v);
      for (int i = 0; i < 3 * FRAME && m_q.size() != 0; i++) step();
      if (m_q.size() != 0) chk("load_wait", {7'b0, ld_ready}, 8'h01);
      ld_valid = 1'b1;
      ld_data  = v;
      step();
      ld_valid = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // 1: reset mid-frame, then blank-first start showing "0"
      run(25);
      wait_pos(5);
      do_reset();
      run(12);

      // 2: load while idle, shown at next frame
      wait_pos(3);
      load(8'h3A);
      chk("ready_drop", {7'b0, ld_ready}, 8'h00);
      run(2 * FRAME);

      // 3: load on the boundary edge bypasses, then a second load is held
      wait_pos(FRAME - 1);
      ld_valid = 1'b1;
      ld_data  = 8'hC5;
      step();
      ld_valid = 1'b0;
      chk("bypass_ready", {7'b0, ld_ready}, 8'h01);
      wait_pos(4);
      load(8'h5E);
      run(FRAME + 10);

      // 4: leading-zero blank
      lzb = 1'b1;
      load(8'h07);
      run(2 * FRAME);
      lzb = 1'b0;
      run(FRAME + 5);

      // 5: display disabled for 1.5 frames
      en = 1'b0;
      run(FRAME + FRAME / 2);
      en = 1'b1;
      run(FRAME);

      // 6: every nibble on both digits
      for (int i = 0; i < 16; i++) begin
         load({4'(i), 4'(15 - i)});
         run(FRAME + 2);
      end

      // random traffic with one reset in the middle
      for (int i = 0; i < 800; i++) begin
         if (i == 400) begin
            ld_valid = 1'b0;
            do_reset();
         end
         ld_valid = ($urandom_range(0, 3) == 0);
         ld_data  = 8'($urandom);
         en       = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) lzb = ~lzb;
         step();
      end
      ld_valid = 1'b0;
      run(FRAME);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
